stats_update_arbiter: RTL
=========================

# stats_update_arbiter

- Shares one set of per-port packet-class counters between NUM_PORTS header-parser result streams.
- Each cycle, a round-robin arbiter pops at most one parser result and applies it to that port's counters one cycle later.
- A register-style read port returns any counter, with optional clear-on-read.
- Sits between the per-port header parsers (fall-through result FIFOs) and the stats register block.

## Interface
- NUM_PORTS, 4, number of parser streams (2..8)
- CNT_WIDTH, 32, counter width in bits
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_vld  in  NUM_PORTS  per-port parser result available (FIFO not empty)
- req_class  in  NUM_PORTS*8  per-port flags, port p at [8p+7:8p]; bit order {arp, ip, ip6, bcast, tcp, udp, syn, fin}, bit 7 = arp
- req_ack  out  NUM_PORTS  one-hot pop to parser FIFO, combinational
- count_en  in  1  1 = apply updates; 0 = drain results without counting
- rd_req  in  1  single-cycle read strobe
- rd_port  in  3  port index
- rd_class  in  4  counter index 0..8
- rd_clear  in  1  clear addressed counter when the read is accepted
- rd_ack  out  1  read data valid, one cycle
- rd_data  out  CNT_WIDTH  counter value

## Operation
- Counters per port, indexed by rd_class: 0 total, 1 arp, 2 ip, 3 ip6, 4 bcast, 5 tcp, 6 udp, 7 syn, 8 fin.
- Arbitration:
  - Round-robin pointer ptr.
  - Grant goes to the first port with req_vld set, searching ptr, ptr+1, … modulo NUM_PORTS.
  - req_ack is one-hot on the granted port and all-zero when no request is present.
  - On a grant, ptr <= granted+1 (wrapping NUM_PORTS-1 -> 0); otherwise ptr holds.
- Capture: on a grant, register {port, req_class, count_en} into stage register upd_*, with upd_vld = 1.
- Update (cycle after grant, if upd_vld and the captured count_en = 1):
  - total += 1.
  - Each class counter whose flag is set += 1; several counters may increment in the same cycle.
- Arithmetic: counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Read:
  - rd_req samples rd_port and rd_class.
  - The registered value is the counter before any update committing in that same cycle.
  - rd_port >= NUM_PORTS or rd_class > 8: rd_data = 0; rd_ack still pulses; no clear.
- Clear-on-read:
  - With rd_clear = 1, the addressed counter becomes 0 at the same edge.
  - If an update to that counter commits at the same edge, the counter becomes 1; the increment is never lost.
- Reset:
  - Ports, counters: all counters 0; req_ack 0 (forced even if req_vld is high); rd_ack 0; rd_data 0.
  - Internal state: ptr 0; upd_vld 0.
- Reset mid-operation: a pending upd_* is discarded, and an in-flight read produces no rd_ack.
- Disallowed input: rd_req with a read in flight cannot occur, because every read completes in one cycle. Back-to-back rd_req is accepted every cycle.

## Timing
- req_vld -> req_ack: 0 cycles (combinational from req_vld and registered ptr). No path from req_class to req_ack.
- Grant to counter visible in a read: the grant at edge N commits at edge N+1. An rd_req sampled at edge N+1 returns the old value; one sampled at N+2 returns the new value.
- rd_req -> rd_ack/rd_data: 1 cycle. rd_data holds its value until the next rd_ack.
- Throughput: one parser result per cycle, aggregate across all ports.
- Fairness: with all ports requesting continuously, each port is granted exactly once every NUM_PORTS cycles.

## Structure
- Shared package stats_pkg:
  - class index constants CLS_TOTAL..CLS_FIN (0..8);
  - NUM_CLASSES = 9;
  - flag bit positions within req_class.
- One sub-module, rr_arbiter:
  - parameter N;
  - ports req[N], grant[N] one-hot, advance;
  - owns the pointer; reused by other stats blocks.
- The counter array and update/read logic live in the top module.

## Test plan
- Reset: hold reset high with req_vld = 4'b1111 -> req_ack = 0. Reading any counter afterwards returns 0.
- Round-robin: req_vld = 4'b1111 held for 8 cycles -> req_ack sequence 0001, 0010, 0100, 1000, 0001, …. Each port's total = 2.
- Classification: port 2 sends class 8'b0100_1010 (ip, tcp, syn) once -> port 2 counters: total = 1, ip = 1, tcp = 1, syn = 1, all others 0. Read returns 1 two cycles after the grant edge.
- Clear/update collision: port 1 tcp = 5. Read with rd_clear on port 1 tcp at the same edge a tcp update commits -> rd_data = 5, counter afterwards = 1.
- Saturation and drain:
  - CNT_WIDTH = 4, 20 grants to port 0 -> total reads 15.
  - With count_en = 0, 3 grants are still acked and the counters are unchanged.
- Bad address: rd_port = 7 (NUM_PORTS = 4) with rd_clear -> rd_ack = 1, rd_data = 0, no counter modified.

Source files
------------

// File: rtl/stats_pkg.sv
// Shared constants for the stats blocks: counter indices, class count and
// the position of each flag within a parser result byte.
package stats_pkg;

  localparam int unsigned NUM_CLASSES = 9;

  localparam int unsigned CLS_TOTAL = 0;
  localparam int unsigned CLS_ARP   = 1;
  localparam int unsigned CLS_IP    = 2;
  localparam int unsigned CLS_IP6   = 3;
  localparam int unsigned CLS_BCAST = 4;
  localparam int unsigned CLS_TCP   = 5;
  localparam int unsigned CLS_UDP   = 6;
  localparam int unsigned CLS_SYN   = 7;
  localparam int unsigned CLS_FIN   = 8;

  localparam int unsigned FLG_ARP   = 7;
  localparam int unsigned FLG_IP    = 6;
  localparam int unsigned FLG_IP6   = 5;
  localparam int unsigned FLG_BCAST = 4;
  localparam int unsigned FLG_TCP   = 3;
  localparam int unsigned FLG_UDP   = 2;
  localparam int unsigned FLG_SYN   = 1;
  localparam int unsigned FLG_FIN   = 0;

  // True when a result with these flags should bump counter cls.
  // Class k (1..8) is flag bit 8-k; the total counter always counts.
  function automatic logic cls_hit(input logic [7:0] flags, input int unsigned cls);
    if (cls == CLS_TOTAL) return 1'b1;
    return flags[3'(CLS_FIN - cls)];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner when the grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  import stats_pkg::*;

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          hit;

  // Search ptr, ptr+1, ... modulo N for the first active request.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    hit   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // Pointer moves to the port after the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && hit) begin
      ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/stats_update_arbiter.sv
// Shared per-port packet-class counters fed by NUM_PORTS parser result
// streams through a round-robin pop, with a one-cycle register read port
// and optional clear-on-read.
module stats_update_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req_vld,
  input  logic [NUM_PORTS*8-1:0] req_class,
  output logic [NUM_PORTS-1:0]   req_ack,
  input  logic                   count_en,
  input  logic                   rd_req,
  input  logic [2:0]             rd_port,
  input  logic [3:0]             rd_class,
  input  logic                   rd_clear,
  output logic                   rd_ack,
  output logic [CNT_WIDTH-1:0]   rd_data
);
  import stats_pkg::*;

  logic [CNT_WIDTH-1:0] cnt [NUM_PORTS][NUM_CLASSES];

  logic                 upd_vld;
  logic [2:0]           upd_port;
  logic [7:0]           upd_class;
  logic                 upd_en;

  logic [NUM_PORTS-1:0] arb_req;
  logic [2:0]           gport;
  logic [7:0]           gclass;
  logic                 rd_valid;
  logic [CNT_WIDTH-1:0] rd_value;
  logic                 inc [NUM_PORTS][NUM_CLASSES];
  logic                 clr [NUM_PORTS][NUM_CLASSES];

  // Masking requests during reset keeps req_ack low even with req_vld high.
  assign arb_req = reset ? '0 : req_vld;

  rr_arbiter #(
    .N (NUM_PORTS)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (1'b1),
    .grant   (req_ack)
  );

  // Encode the one-hot grant and select the winner's class flags.
  always_comb begin
    gport  = '0;
    gclass = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req_ack[p]) begin
        gport  = 3'(p);
        gclass = req_class[p*8 +: 8];
      end
    end
  end

  // Decode the read address and per-counter increment/clear enables.
  always_comb begin
    rd_valid = ({1'b0, rd_port} < 4'(NUM_PORTS)) && (rd_class < 4'(NUM_CLASSES));
    rd_value = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        inc[p][c] = upd_vld && upd_en && (upd_port == 3'(p)) && cls_hit(upd_class, c);
        clr[p][c] = rd_req && rd_clear && rd_valid &&
                    (rd_port == 3'(p)) && (rd_class == 4'(c));
        if (rd_valid && (rd_port == 3'(p)) && (rd_class == 4'(c))) rd_value = cnt[p][c];
      end
    end
  end

  // Capture the granted result for application on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_vld   <= 1'b0;
      upd_port  <= '0;
      upd_class <= '0;
      upd_en    <= 1'b0;
    end else begin
      upd_vld <= |req_ack;
      if (|req_ack) begin
        upd_port  <= gport;
        upd_class <= gclass;
        upd_en    <= count_en;
      end
    end
  end

  // Counter update: a clear colliding with an increment leaves 1 so the
  // increment is not lost; otherwise increments saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
          cnt[p][c] <= '0;
        end
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
          if (clr[p][c]) begin
            cnt[p][c] <= inc[p][c] ? CNT_WIDTH'(1) : '0;
          end else if (inc[p][c] && (cnt[p][c] != '1)) begin
            cnt[p][c] <= cnt[p][c] + 1'b1;
          end
        end
      end
    end
  end

  // Read port: one-cycle response; data holds until the next response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) rd_data <= rd_value;
    end
  end

endmodule
